rule_ca_sequencer: RTL and testbench
====================================

RULE_CA_SEQUENCER -- requirements
Module: rule_ca_sequencer

Interface
REQ-001 Parameter W, default 512, meaning: automaton width in cells.
REQ-002 Parameter CW, default 16, meaning: width of generation counters.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 areset_n  input  1  reset, asynchronous and active-low.
REQ-005 start_valid  input  1  job request.
REQ-006 start_ready  output  1  sequencer accepts a job; high only in IDLE.
REQ-007 seed  input  W  initial cell state; sampled on start accept.
REQ-008 rule  input  8  elementary CA rule number; sampled on start accept.
REQ-009 wrap  input  1  boundary mode (0 = zero boundary, 1 = circular); sampled on start accept.
REQ-010 gens  input  CW  number of generations to run; sampled on start accept.
REQ-011 abort  input  1  cancel the running job.
REQ-012 busy  output  1  high in RUN.
REQ-013 q  output  W  current cell state.
REQ-014 gen_count  output  CW  generations applied in the current job.
REQ-015 stable  output  1  job ended early on a fixed point.
REQ-016 done_valid  output  1  result available; high only in DONE.
REQ-017 done_ready  input  1  consumer accepts result.

Function
REQ-018 FSM states IDLE, RUN, DONE; one-hot or binary encoding is free.
REQ-019 Neighbourhood of cell i: left = q[i+1], centre = q[i], right = q[i-1]; next[i] = rule[{left,centre,right}].
REQ-020 Zero boundary: left of cell W-1 and right of cell 0 read 0; wrap boundary: they read q[0] and q[W-1] respectively.
REQ-021 Rule 110 (0x6E) with zero boundary matches the existing rule-110 datapath bit-for-bit.
REQ-022 IDLE, start_valid & start_ready: q <= seed, rule/wrap/gens latched, gen_count <= 0, stable <= 0; go RUN if gens != 0, else DONE directly.
REQ-023 RUN: one generation per cycle; q <= next, gen_count <= gen_count + 1.
REQ-024 RUN: if next == q (fixed point), stable <= 1 and go DONE in the same edge as that step.
REQ-025 RUN: when gen_count + 1 == latched gens, go DONE; latency from accept to done_valid = gens cycles, or fewer on a fixed point.
REQ-026 RUN: abort has priority over step; q and gen_count hold, go IDLE, no done_valid pulse.
REQ-027 DONE: q, gen_count and stable hold; done_valid high until done_ready; on done_valid & done_ready go IDLE.
REQ-028 start_valid outside IDLE ignored; abort outside RUN ignored.
REQ-029 Input changes to seed/rule/wrap/gens after accept have no effect on the running job.

Reset
REQ-030 areset_n low: state IDLE, q = 0, gen_count = 0, stable = 0, busy = 0, done_valid = 0, start_ready = 1 on the first cycle after release.
REQ-031 Reset asserted mid-RUN or mid-DONE discards the job immediately, with no done_valid.

Structure
REQ-032 Package ca_pkg holds the state enum, RULE_110 = 8'h6E, and default W/CW constants.
REQ-033 Next-state logic lives in one combinational sub-module ca_step (inputs q, rule, wrap; output next).

Verification
REQ-034 W=512, rule 0x6E, zero boundary, seed = 1, gens = 2 -> q = 0x3 after cycle 1, q = 0x7 at done; gen_count = 2; stable = 0.
REQ-035 Seed = 0, rule 0x6E, gens = 100 -> done after 1 cycle, gen_count = 1, stable = 1, q = 0.
REQ-036 Rule 0xF0, seed = 1, gens = 1: wrap = 1 -> q = bit W-1 only; wrap = 0 -> q = 0.
REQ-037 gens = 0 -> DONE on the cycle after accept, q = seed, gen_count = 0.
REQ-038 Abort at gen_count = 3 of 10 -> IDLE, q holds gen-3 value, no done_valid; then done_ready held low 5 cycles on the next job -> done_valid and q stay stable throughout.
REQ-039 areset_n pulsed mid-RUN -> all outputs at reset values asynchronously, start_ready = 1 after release.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared definitions for the elementary cellular-automaton sequencer.
//   state_e    : sequencer FSM states
//   RULE_110   : rule number of the legacy rule-110 datapath
//   W_DEFAULT  : default automaton width in cells
//   CW_DEFAULT : default generation-counter width
package ca_pkg;

  localparam int unsigned W_DEFAULT  = 512;
  localparam int unsigned CW_DEFAULT = 16;
  localparam logic [7:0]  RULE_110   = 8'h6E;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ca_step.sv
// One generation of an elementary cellular automaton (combinational).
//   q    : current cell state, W cells
//   rule : 8-bit rule number, indexed by {left,centre,right}
//   wrap : 0 = cells beyond the edges read 0, 1 = circular boundary
//   next : next cell state
module ca_step
  import ca_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] q,
  input  logic [7:0]   rule,
  input  logic         wrap,
  output logic [W-1:0] next
);

  // ext = {left of cell W-1, q, right of cell 0}; cell i sees ext[i+2:i]
  // as {left, centre, right}, so every index stays in range.
  logic [W+1:0] ext;

  always_comb begin
    ext = {(wrap & q[0]), q, (wrap & q[W-1])};
    next = '0;
    for (int unsigned i = 0; i < W; i++) begin
      next[i] = rule[ext[i +: 3]];
    end
  end

endmodule

// File: rtl/rule_ca_sequencer.sv
// Runs an elementary CA job: latches seed/rule/boundary/generation count on
// start, steps one generation per cycle, stops early on a fixed point, and
// holds the result until the consumer takes it.
//   clk, areset_n          : clock, asynchronous active-low reset
//   start_valid/ready      : job request handshake (ready only in IDLE)
//   seed, rule, wrap, gens : job parameters, sampled on start accept
//   abort                  : cancel the running job (RUN only)
//   busy                   : high in RUN
//   q, gen_count, stable   : cell state, generations applied, fixed-point flag
//   done_valid/ready       : result handshake (valid only in DONE)
module rule_ca_sequencer
  import ca_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [W-1:0]  seed,
  input  logic [7:0]    rule,
  input  logic          wrap,
  input  logic [CW-1:0] gens,
  input  logic          abort,
  output logic          busy,
  output logic [W-1:0]  q,
  output logic [CW-1:0] gen_count,
  output logic          stable,
  output logic          done_valid,
  input  logic          done_ready
);

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] gen_q, gen_d;
  logic [CW-1:0] gens_q, gens_d;
  logic [7:0]    rule_q, rule_d;
  logic          wrap_q, wrap_d;
  logic          stable_q, stable_d;
  logic [W-1:0]  next;
  logic [CW-1:0] gen_inc;

  ca_step #(.W(W)) u_step (
    .q    (q_q),
    .rule (rule_q),
    .wrap (wrap_q),
    .next (next)
  );

  assign gen_inc = gen_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    gen_d    = gen_q;
    gens_d   = gens_q;
    rule_d   = rule_q;
    wrap_d   = wrap_q;
    stable_d = stable_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          q_d      = seed;
          rule_d   = rule;
          wrap_d   = wrap;
          gens_d   = gens;
          gen_d    = '0;
          stable_d = 1'b0;
          state_d  = (gens != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          q_d   = next;
          gen_d = gen_inc;
          if (next == q_q) begin
            stable_d = 1'b1;
            state_d  = S_DONE;
          end else if (gen_inc == gens_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      gen_q    <= '0;
      gens_q   <= '0;
      rule_q   <= '0;
      wrap_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      gen_q    <= gen_d;
      gens_q   <= gens_d;
      rule_q   <= rule_d;
      wrap_q   <= wrap_d;
      stable_q <= stable_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign done_valid  = (state_q == S_DONE);
  assign q           = q_q;
  assign gen_count   = gen_q;
  assign stable      = stable_q;

endmodule

// File: tb/tb_rule_ca_sequencer.sv
// Directed self-checking bench for rule_ca_sequencer (W=512, CW=16).
module tb_rule_ca_sequencer;
  import ca_pkg::*;

  localparam int unsigned W  = 512;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          areset_n;
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  seed;
  logic [7:0]    rule;
  logic          wrap;
  logic [CW-1:0] gens;
  logic          abort;
  logic          busy;
  logic [W-1:0]  q;
  logic [CW-1:0] gen_count;
  logic          stable;
  logic          done_valid;
  logic          done_ready;

  int unsigned tests = 0;
  int unsigned fails = 0;

  rule_ca_sequencer #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .seed        (seed),
    .rule        (rule),
    .wrap        (wrap),
    .gens        (gens),
    .abort       (abort),
    .busy        (busy),
    .q           (q),
    .gen_count   (gen_count),
    .stable      (stable),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a job for one edge, then scrambles the job inputs so any
  // late sampling would corrupt the result.
  task automatic start_job(input logic [W-1:0] s, input logic [7:0] r,
                           input logic wr, input logic [CW-1:0] g);
    seed = s; rule = r; wrap = wr; gens = g; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    seed = {16{$urandom()}};
    rule = 8'($urandom());
    wrap = ~wr;
    gens = 16'd7;
  endtask

  task automatic finish_job();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("back_to_idle", W'(start_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] top_bit;
    top_bit = '0;
    top_bit[W-1] = 1'b1;

    areset_n = 1'b0; start_valid = 1'b0; seed = '0; rule = '0; wrap = 1'b0;
    gens = '0; abort = 1'b0; done_ready = 1'b0;
    #12 areset_n = 1'b1;
    tick();
    check("rst_start_ready", W'(start_ready), W'(1));
    check("rst_busy",        W'(busy),        W'(0));
    check("rst_done_valid",  W'(done_valid),  W'(0));
    check("rst_q",           q,               '0);
    check("rst_gen_count",   W'(gen_count),   W'(0));
    check("rst_stable",      W'(stable),      W'(0));

    // Rule 110, zero boundary, seed 1, two generations.
    start_job(W'(1), RULE_110, 1'b0, 16'd2);
    tick();
    check("r110_g1_q",    q,               W'(3));
    check("r110_g1_busy", W'(busy),        W'(1));
    check("r110_g1_cnt",  W'(gen_count),   W'(1));
    tick();
    check("r110_done_v",  W'(done_valid),  W'(1));
    check("r110_done_q",  q,               W'(7));
    check("r110_cnt",     W'(gen_count),   W'(2));
    check("r110_stable",  W'(stable),      W'(0));
    finish_job();

    // Fixed point: all-zero seed under rule 110 stops after one step.
    start_job('0, RULE_110, 1'b0, 16'd100);
    tick();
    check("fp_done_v", W'(done_valid), W'(1));
    check("fp_cnt",    W'(gen_count),  W'(1));
    check("fp_stable", W'(stable),     W'(1));
    check("fp_q",      q,              '0);
    finish_job();

    // Rule 0xF0 copies the left neighbour: boundary decides bit W-1.
    start_job(W'(1), 8'hF0, 1'b1, 16'd1);
    tick();
    check("f0_wrap_v", W'(done_valid), W'(1));
    check("f0_wrap_q", q,              top_bit);
    finish_job();
    start_job(W'(1), 8'hF0, 1'b0, 16'd1);
    tick();
    check("f0_zero_v", W'(done_valid), W'(1));
    check("f0_zero_q", q,              '0);
    finish_job();

    // Zero generations: straight to DONE with the seed.
    start_job(W'(512'hABCD), RULE_110, 1'b0, 16'd0);
    check("g0_done_v", W'(done_valid), W'(1));
    check("g0_busy",   W'(busy),       W'(0));
    check("g0_q",      q,              W'(512'hABCD));
    check("g0_cnt",    W'(gen_count),  W'(0));
    finish_job();

    // Abort after three generations (seed 1 -> 3 -> 7 -> D).
    start_job(W'(1), RULE_110, 1'b0, 16'd10);
    tick(); tick(); tick();
    check("ab_pre_cnt", W'(gen_count), W'(3));
    check("ab_pre_q",   q,             W'(4'hD));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle",    W'(start_ready), W'(1));
    check("ab_no_done", W'(done_valid),  W'(0));
    check("ab_q_hold",  q,               W'(4'hD));
    check("ab_cnt",     W'(gen_count),   W'(3));
    tick();
    check("ab_stay_idle", W'(done_valid), W'(0));

    // Consumer stalls for five cycles; stray start/abort must be ignored.
    start_job(W'(1), RULE_110, 1'b0, 16'd2);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      start_valid = (i == 1);
      abort = (i == 2);
      check("stall_valid", W'(done_valid), W'(1));
      check("stall_q",     q,              W'(7));
      tick();
    end
    start_valid = 1'b0;
    abort = 1'b0;
    check("stall_cnt", W'(gen_count), W'(2));
    finish_job();
    check("post_no_done", W'(done_valid), W'(0));

    // Asynchronous reset in the middle of a job.
    start_job(W'(1), RULE_110, 1'b0, 16'd10);
    tick(); tick();
    #2 areset_n = 1'b0;
    #1;
    check("ar_busy",   W'(busy),       W'(0));
    check("ar_q",      q,              '0);
    check("ar_cnt",    W'(gen_count),  W'(0));
    check("ar_done_v", W'(done_valid), W'(0));
    check("ar_ready",  W'(start_ready), W'(1));
    #10 areset_n = 1'b1;
    tick();
    check("ar_rel_ready", W'(start_ready), W'(1));
    check("ar_rel_done",  W'(done_valid),  W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
